// File: rtl/chaining_record_table.sv
// Record table of in-flight vector instructions used for chaining checks.
// Each slot tracks a destination group, instruction index and a 256-bit element-written mask.
module chaining_record_table #(
    parameter int NUM_RECORDS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic                       enq_bits_vd_valid,
    input  logic [4:0]                 enq_bits_vd,
    input  logic [2:0]                 enq_bits_instIndex,
    input  logic [255:0]               enq_bits_elementMask,
    input  logic                       wb_valid,
    input  logic [2:0]                 wb_instIndex,
    input  logic [2:0]                 wb_vdOffset,
    input  logic [4:0]                 wb_offset,
    input  logic                       retire_valid,
    input  logic [2:0]                 retire_instIndex,
    output logic [NUM_RECORDS-1:0]     record_valid,
    output logic [NUM_RECORDS-1:0]     record_vd_valid,
    output logic [5*NUM_RECORDS-1:0]   record_vd,
    output logic [3*NUM_RECORDS-1:0]   record_instIndex,
    output logic [256*NUM_RECORDS-1:0] record_elementMask,
    output logic [NUM_RECORDS-1:0]     record_done
);

    logic         r_valid      [NUM_RECORDS];
    logic         r_vd_valid   [NUM_RECORDS];
    logic [4:0]   r_vd         [NUM_RECORDS];
    logic [2:0]   r_inst_index [NUM_RECORDS];
    logic [255:0] r_mask       [NUM_RECORDS];

    logic [NUM_RECORDS-1:0] w_free;
    logic [NUM_RECORDS-1:0] w_dup;
    logic [NUM_RECORDS-1:0] w_alloc;
    logic [NUM_RECORDS-1:0] w_wb_hit;
    logic [NUM_RECORDS-1:0] w_ret_hit;
    logic                   w_enq_fire;
    logic [7:0]             w_wb_bit;

    assign w_wb_bit   = {wb_vdOffset, wb_offset};
    assign enq_ready  = (|w_free) && !(|w_dup);
    assign w_enq_fire = enq_valid && enq_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RECORDS; gi++) begin : g_slot
            assign w_free[gi]    = !r_valid[gi];
            assign w_dup[gi]     = r_valid[gi] && (r_inst_index[gi] == enq_bits_instIndex);
            assign w_wb_hit[gi]  = wb_valid && r_valid[gi] && r_vd_valid[gi]
                                   && (r_inst_index[gi] == wb_instIndex);
            assign w_ret_hit[gi] = retire_valid && r_valid[gi]
                                   && (r_inst_index[gi] == retire_instIndex);

            // Priority encoder: only the lowest-numbered free slot takes a new record.
            if (gi == 0) begin : g_first
                assign w_alloc[gi] = w_free[gi];
            end else begin : g_rest
                assign w_alloc[gi] = w_free[gi] && !(|w_free[gi-1:0]);
            end

            assign record_valid[gi]               = r_valid[gi];
            assign record_vd_valid[gi]            = r_vd_valid[gi];
            assign record_vd[5*gi +: 5]           = r_vd[gi];
            assign record_instIndex[3*gi +: 3]    = r_inst_index[gi];
            assign record_elementMask[256*gi +: 256] = r_mask[gi];
            assign record_done[gi]                = r_valid[gi] && (&r_mask[gi]);
        end
    endgenerate

    // A freshly allocated slot was free at start of cycle, so retire and
    // write-back can never target it in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_RECORDS; i++) begin
                r_valid[i]      <= 1'b0;
                r_vd_valid[i]   <= 1'b0;
                r_vd[i]         <= '0;
                r_inst_index[i] <= '0;
                r_mask[i]       <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RECORDS; i++) begin
                if (w_ret_hit[i]) begin
                    r_valid[i]    <= 1'b0;
                    r_vd_valid[i] <= 1'b0;
                    r_mask[i]     <= '0;
                end else if (w_enq_fire && w_alloc[i]) begin
                    r_valid[i]      <= 1'b1;
                    r_vd_valid[i]   <= enq_bits_vd_valid;
                    r_vd[i]         <= enq_bits_vd;
                    r_inst_index[i] <= enq_bits_instIndex;
                    r_mask[i]       <= enq_bits_elementMask;
                end else if (w_wb_hit[i]) begin
                    r_mask[i][w_wb_bit] <= 1'b1;
                end
            end
        end
    end

endmodule
